// File: rtl/mac_tx_arb.sv
// rtl/mac_tx_arb.sv - round-robin arbiter sharing the MAC TX byte path between N frame sources
package mac_tx_arb_pkg;
    typedef struct packed {
        logic        val;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ethertype;
        logic [15:0] length;
    } mac_meta_t;
endpackage

module mac_tx_arb
    import mac_tx_arb_pkg::*;
#(
    parameter int N         = 2,
    parameter int IFG_BYTES = 12,
    parameter int WDOG      = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  mac_meta_t [N-1:0] meta,
    input  logic [N-1:0][7:0] dat,
    input  logic [N-1:0]      val,
    input  logic [N-1:0]      last,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rdy,
    output logic [N-1:0]      abort,
    output mac_meta_t         mac_meta,
    output logic [7:0]        mac_dat,
    output logic              mac_val,
    output logic              mac_sof,
    output logic              mac_eof,
    output logic              mac_err,
    input  logic              mac_rdy,
    output logic              busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (IFG_BYTES > 0) ? $clog2(IFG_BYTES + 1) : 1;
    localparam int WW = (WDOG > 0) ? $clog2(WDOG + 1) : 1;
    localparam logic [PW-1:0] SEL_MAX   = PW'(N - 1);
    localparam logic [IW-1:0] IFG_LAST  = IW'(IFG_BYTES - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_IFG} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  sel;
    logic [PW-1:0]  pick;
    logic [IW-1:0]  ifg_cnt;
    logic [WW-1:0]  wdog_cnt;
    logic           started;
    logic           val_sel;
    logic           accept;
    logic           wdog_fire;
    logic           frame_end;

    assign val_sel   = val[sel];
    assign accept    = (state == S_XFER) && val_sel && mac_rdy;
    // A stalled source is cut off on its WDOG-th consecutive cycle without val.
    assign wdog_fire = (WDOG > 0) && (state == S_XFER) && !val_sel && (wdog_cnt == WDOG_LAST);
    assign frame_end = (accept && last[sel]) || wdog_fire;

    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_GRANT;
            S_GRANT: state_nxt = S_XFER;
            S_XFER:  if (frame_end) state_nxt = (IFG_BYTES > 0) ? S_IFG : S_IDLE;
            S_IFG:   if (ifg_cnt == IFG_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            sel      <= '0;
            mac_meta <= '0;
            ifg_cnt  <= '0;
            wdog_cnt <= '0;
            started  <= 1'b0;
        end else begin
            if (state == S_IDLE && |req) begin
                sel      <= pick;
                mac_meta <= meta[pick];
            end
            if (state == S_XFER) begin
                started  <= started | accept;
                // Backpressure with val high is not a stall, so any val clears the count.
                wdog_cnt <= val_sel ? '0 : wdog_cnt + WW'(1);
                if (frame_end) begin
                    ptr <= (sel == SEL_MAX) ? '0 : sel + PW'(1);
                end
            end else begin
                started  <= 1'b0;
                wdog_cnt <= '0;
            end
            ifg_cnt <= (state == S_IFG) ? ifg_cnt + IW'(1) : '0;
        end
    end

    always_comb begin
        gnt     = '0;
        rdy     = '0;
        abort   = '0;
        mac_dat = '0;
        mac_val = 1'b0;
        mac_sof = 1'b0;
        mac_eof = 1'b0;
        mac_err = 1'b0;
        busy    = (state != S_IDLE);
        case (state)
            S_GRANT: begin
                gnt[sel] = 1'b1;
            end
            S_XFER: begin
                gnt[sel]   = 1'b1;
                rdy[sel]   = mac_rdy;
                abort[sel] = wdog_fire;
                mac_dat    = dat[sel];
                mac_val    = val_sel || wdog_fire;
                mac_sof    = accept && !started;
                mac_eof    = frame_end;
                mac_err    = wdog_fire;
            end
            default: begin
            end
        endcase
    end

endmodule
